// File: rtl/fetch_sequencer.sv
// Purpose: program counter, fetch register, fetch/execute phase and C/Z flags feeding the decoder.
// Latency: a ROM byte presented during FETCH lands on instr/oprnd one edge later, with phase=1.
// Backpressure: enable=0 freezes all state and ignores every strobe; reset overrides enable.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   enable               global advance qualifier
//   program_byte         combinational ROM data at address pc ({instr, oprnd})
//   inc_pc, load_pc      PC strobes from the decoder (load wins over increment)
//   load_addr            jump target
//   flags_we, c_in, z_in flag write strobe and ALU carry/zero
//   pc                   ROM address
//   instr, oprnd         captured opcode and operand
//   c_flag, z_flag       registered flags
//   phase                0 = fetch, 1 = execute
//   decode_in            {instr, c_flag, z_flag, phase}, a pure concat of registers
module fetch_sequencer #(
  parameter int PC_W = 12
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [7:0]      program_byte,
  input  logic            inc_pc,
  input  logic            load_pc,
  input  logic [PC_W-1:0] load_addr,
  input  logic            flags_we,
  input  logic            c_in,
  input  logic            z_in,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      instr,
  output logic [3:0]      oprnd,
  output logic            c_flag,
  output logic            z_flag,
  output logic            phase,
  output logic [6:0]      decode_in
);

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } state_t;

  state_t state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= '0;
      instr  <= 4'h0;
      oprnd  <= 4'h0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (enable) begin
      // Strobes are only looked at under enable, so garbage on them while
      // frozen cannot reach the state.
      case (state)
        FETCH: begin
          {instr, oprnd} <= program_byte;
          state          <= EXECUTE;
        end
        default: begin
          state <= FETCH;
        end
      endcase

      // PC strobes act in either phase; the increment wraps naturally at PC_W bits.
      if (load_pc) begin
        pc <= load_addr;
      end else if (inc_pc) begin
        pc <= pc + 1'b1;
      end

      if (flags_we) begin
        c_flag <= c_in;
        z_flag <= z_in;
      end
    end
  end

  assign phase     = (state == EXECUTE);
  assign decode_in = {instr, c_flag, z_flag, phase};

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural ROM drives program_byte from pc,
// and each step checks hand-computed register values one time unit after the edge.
module tb_fetch_sequencer;

  localparam int PC_W = 12;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [7:0]      program_byte;
  logic            inc_pc;
  logic            load_pc;
  logic [PC_W-1:0] load_addr;
  logic            flags_we;
  logic            c_in;
  logic            z_in;
  logic [PC_W-1:0] pc;
  logic [3:0]      instr;
  logic [3:0]      oprnd;
  logic            c_flag;
  logic            z_flag;
  logic            phase;
  logic [6:0]      decode_in;

  logic [7:0] rom [0:(1<<PC_W)-1];

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.PC_W(PC_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .program_byte (program_byte),
    .inc_pc       (inc_pc),
    .load_pc      (load_pc),
    .load_addr    (load_addr),
    .flags_we     (flags_we),
    .c_in         (c_in),
    .z_in         (z_in),
    .pc           (pc),
    .instr        (instr),
    .oprnd        (oprnd),
    .c_flag       (c_flag),
    .z_flag       (z_flag),
    .phase        (phase),
    .decode_in    (decode_in)
  );

  always #5 clock = ~clock;

  // Asynchronous ROM: combinational read at the current pc.
  assign program_byte = rom[pc];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_strobes();
    inc_pc    = 1'b0;
    load_pc   = 1'b0;
    load_addr = '0;
    flags_we  = 1'b0;
    c_in      = 1'b0;
    z_in      = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << PC_W); i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h3A;
    rom[12'h001] = 8'h5C;
    rom[12'h010] = 8'h91;
    rom[12'h7F3] = 8'hE4;
    rom[12'hFFF] = 8'h27;

    reset  = 1'b1;
    enable = 1'b1;
    idle_strobes();
    step();
    check("rst_pc",     pc,        12'h000);
    check("rst_phase",  phase,     1'b0);
    check("rst_decode", decode_in, 7'b0000000);

    // Straight-line fetch, inc_pc only in FETCH.
    reset  = 1'b0;
    inc_pc = 1'b1;
    step();
    check("f1_instr",  instr,     4'h3);
    check("f1_oprnd",  oprnd,     4'hA);
    check("f1_phase",  phase,     1'b1);
    check("f1_pc",     pc,        12'h001);
    check("f1_decode", decode_in, 7'b0011001);
    inc_pc = 1'b0;
    step();
    check("e1_phase", phase, 1'b0);
    check("e1_instr_hold", instr, 4'h3);
    check("e1_pc_hold", pc, 12'h001);
    inc_pc = 1'b1;
    step();
    check("f2_instr", instr, 4'h5);
    check("f2_oprnd", oprnd, 4'hC);
    check("f2_pc",    pc,    12'h002);

    // Jump in EXECUTE to 0x010, then load+inc together in FETCH.
    inc_pc    = 1'b0;
    load_pc   = 1'b1;
    load_addr = 12'h010;
    step();
    check("j0_pc",    pc,    12'h010);
    check("j0_phase", phase, 1'b0);
    inc_pc    = 1'b1;
    load_addr = 12'h7F3;
    step();
    check("jp_pc",    pc,    12'h7F3);
    check("jp_instr", instr, 4'h9);
    idle_strobes();
    step();
    step();
    check("jt_instr", instr, 4'hE);
    check("jt_oprnd", oprnd, 4'h4);
    check("jt_pc",    pc,    12'h7F3);

    // Wrap 0xFFF -> 0x000.
    load_pc   = 1'b1;
    load_addr = 12'hFFF;
    step();
    check("w0_pc", pc, 12'hFFF);
    idle_strobes();
    inc_pc = 1'b1;
    step();
    check("wrap_pc",    pc,    12'h000);
    check("wrap_instr", instr, 4'h2);
    check("wrap_phase", phase, 1'b1);

    // Flags written in EXECUTE, then held, then rewritten.
    idle_strobes();
    flags_we = 1'b1;
    c_in     = 1'b1;
    z_in     = 1'b0;
    step();
    check("fl_c",      c_flag,         1'b1);
    check("fl_z",      z_flag,         1'b0);
    check("fl_decode", decode_in[2:1], 2'b10);
    flags_we = 1'b0;
    c_in     = 1'b0;
    z_in     = 1'b1;
    step();
    check("flh_c", c_flag, 1'b1);
    check("flh_z", z_flag, 1'b0);
    flags_we = 1'b1;
    c_in     = 1'b1;
    z_in     = 1'b1;
    step();
    check("flw_z", z_flag, 1'b1);

    // Advance once so pc/phase are nonzero, then freeze with all strobes active.
    idle_strobes();
    inc_pc = 1'b1;
    step();
    check("pre_pc",    pc,    12'h001);
    check("pre_phase", phase, 1'b1);
    enable    = 1'b0;
    load_pc   = 1'b1;
    load_addr = 12'h555;
    flags_we  = 1'b1;
    c_in      = 1'b0;
    z_in      = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("frz_pc",     pc,        12'h001);
    check("frz_phase",  phase,     1'b1);
    check("frz_c",      c_flag,    1'b1);
    check("frz_z",      z_flag,    1'b1);
    check("frz_decode", decode_in, 7'b0011111);

    // Reset in EXECUTE while enable=0.
    reset = 1'b1;
    step();
    check("mrst_pc",     pc,        12'h000);
    check("mrst_phase",  phase,     1'b0);
    check("mrst_instr",  instr,     4'h0);
    check("mrst_decode", decode_in, 7'b0000000);

    // First enabled edge after reset fetches address 0.
    reset  = 1'b0;
    enable = 1'b1;
    idle_strobes();
    step();
    check("prst_instr", instr, 4'h3);
    check("prst_oprnd", oprnd, 4'hA);
    check("prst_phase", phase, 1'b1);
    check("prst_pc",    pc,    12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
